rx_rudi_decoder: RTL and testbench

RX_RUDI_DECODER -- requirements
Module: rx_rudi_decoder

---
 rtl/rx_rudi_decoder_if.sv | 26 ++
 rtl/rx_rudi_decoder.sv | 131 +++++++++++++
 tb/tb_rx_rudi_decoder.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/rx_rudi_decoder_if.sv
// Receive-side code-group stream in, RUDI indications and config word out.
interface rx_rudi_decoder_if;
    logic        i_Cke;
    logic        i_SyncStatus;
    logic [7:0]  i8_RxCodeGroup;
    logic        i_RxCtrl;
    logic        i_RxCodeErr;
    logic        i_ClrCnt;
    logic        o_RUDIConfig;
    logic        o_RUDIIdle;
    logic        o_RUDIInvalid;
    logic [15:0] o16_RxConfigReg;
    logic [7:0]  o8_InvalidCnt;

    // Code-group source side
    modport master (
        output i_Cke, i_SyncStatus, i8_RxCodeGroup, i_RxCtrl, i_RxCodeErr, i_ClrCnt,
        input  o_RUDIConfig, o_RUDIIdle, o_RUDIInvalid, o16_RxConfigReg, o8_InvalidCnt
    );

    // Decoder side
    modport slave (
        input  i_Cke, i_SyncStatus, i8_RxCodeGroup, i_RxCtrl, i_RxCodeErr, i_ClrCnt,
        output o_RUDIConfig, o_RUDIIdle, o_RUDIInvalid, o16_RxConfigReg, o8_InvalidCnt
    );
endinterface

// File: rtl/rx_rudi_decoder.sv
// RUDI ordered-set decoder: recognises /C/ and /I/ sets, flags invalid code
// groups, keeps the last config word and a saturating invalid-event count.
module rx_rudi_decoder (
    input  logic                i_Clk,
    input  logic                i_ARst_L,
    rx_rudi_decoder_if.slave    bus
);
    localparam int unsigned CG_W  = 8;
    localparam int unsigned CFG_W = 16;

    localparam logic [CG_W-1:0] K28_5 = 8'hBC;
    localparam logic [CG_W-1:0] D21_5 = 8'hB5;
    localparam logic [CG_W-1:0] D2_2  = 8'h42;
    localparam logic [CG_W-1:0] D5_6  = 8'hC5;
    localparam logic [CG_W-1:0] D16_2 = 8'h50;

    typedef enum logic [1:0] {
        stWAIT_K,
        stGOT_K,
        stCFG_LO,
        stCFG_HI
    } state_e;

    state_e             state_q, state_d;
    logic               cfg_pls_q, cfg_pls_d;
    logic               idle_pls_q, idle_pls_d;
    logic               inv_pls_q, inv_pls_d;
    logic [CG_W-1:0]    lo_byte_q, lo_byte_d;
    logic [CFG_W-1:0]   cfg_reg_q, cfg_reg_d;
    logic [CG_W-1:0]    inv_cnt_q, inv_cnt_d;

    logic               is_comma;

    assign is_comma = bus.i_RxCtrl && (bus.i8_RxCodeGroup == K28_5);

    // Next-state, pulse, config capture and invalid counter
    always_comb begin
        state_d    = state_q;
        cfg_pls_d  = 1'b0;
        idle_pls_d = 1'b0;
        inv_pls_d  = 1'b0;
        lo_byte_d  = lo_byte_q;
        cfg_reg_d  = cfg_reg_q;
        inv_cnt_d  = inv_cnt_q;

        if (!bus.i_SyncStatus) begin
            // Loss of sync silences everything, including code errors
            state_d = stWAIT_K;
        end else if (bus.i_Cke) begin
            if (bus.i_RxCodeErr) begin
                inv_pls_d = 1'b1;
                state_d   = stWAIT_K;
            end else begin
                unique case (state_q)
                    stWAIT_K: begin
                        if (is_comma) begin
                            state_d = stGOT_K;
                        end else if (bus.i_RxCtrl) begin
                            inv_pls_d = 1'b1;
                        end
                    end
                    stGOT_K: begin
                        if (is_comma) begin
                            state_d = stGOT_K;
                        end else if (!bus.i_RxCtrl &&
                                     (bus.i8_RxCodeGroup == D21_5 || bus.i8_RxCodeGroup == D2_2)) begin
                            state_d = stCFG_LO;
                        end else if (!bus.i_RxCtrl &&
                                     (bus.i8_RxCodeGroup == D5_6 || bus.i8_RxCodeGroup == D16_2)) begin
                            idle_pls_d = 1'b1;
                            state_d    = stWAIT_K;
                        end else begin
                            inv_pls_d = 1'b1;
                            state_d   = stWAIT_K;
                        end
                    end
                    stCFG_LO, stCFG_HI: begin
                        if (bus.i_RxCtrl) begin
                            // A K inside the config payload aborts the set;
                            // a comma may start the next one immediately
                            inv_pls_d = 1'b1;
                            state_d   = is_comma ? stGOT_K : stWAIT_K;
                        end else if (state_q == stCFG_LO) begin
                            lo_byte_d = bus.i8_RxCodeGroup;
                            state_d   = stCFG_HI;
                        end else begin
                            cfg_reg_d = {bus.i8_RxCodeGroup, lo_byte_q};
                            cfg_pls_d = 1'b1;
                            state_d   = stWAIT_K;
                        end
                    end
                    default: state_d = stWAIT_K;
                endcase
            end
        end

        if (bus.i_ClrCnt) begin
            inv_cnt_d = '0;
        end else if (inv_pls_d && (inv_cnt_q != {CG_W{1'b1}})) begin
            inv_cnt_d = inv_cnt_q + CG_W'(1);
        end
    end

    // State and output registers
    always_ff @(posedge i_Clk or negedge i_ARst_L) begin
        if (!i_ARst_L) begin
            state_q    <= stWAIT_K;
            cfg_pls_q  <= 1'b0;
            idle_pls_q <= 1'b0;
            inv_pls_q  <= 1'b0;
            lo_byte_q  <= '0;
            cfg_reg_q  <= '0;
            inv_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            cfg_pls_q  <= cfg_pls_d;
            idle_pls_q <= idle_pls_d;
            inv_pls_q  <= inv_pls_d;
            lo_byte_q  <= lo_byte_d;
            cfg_reg_q  <= cfg_reg_d;
            inv_cnt_q  <= inv_cnt_d;
        end
    end

    assign bus.o_RUDIConfig    = cfg_pls_q;
    assign bus.o_RUDIIdle      = idle_pls_q;
    assign bus.o_RUDIInvalid   = inv_pls_q;
    assign bus.o16_RxConfigReg = cfg_reg_q;
    assign bus.o8_InvalidCnt   = inv_cnt_q;

endmodule

// File: tb/tb_rx_rudi_decoder.sv
// Self-checking bench for rx_rudi_decoder: directed ordered-set scenarios
// followed by randomized code-group traffic against an ordered-set model.
module tb_rx_rudi_decoder;
    logic i_Clk;
    logic i_ARst_L;

    rx_rudi_decoder_if bus_if ();

    rx_rudi_decoder dut (
        .i_Clk    (i_Clk),
        .i_ARst_L (i_ARst_L),
        .bus      (bus_if)
    );

    initial begin
        i_Clk = 1'b0;
        forever #5 i_Clk = ~i_Clk;
    end

    int checks = 0;
    int errors = 0;

    // Expected outputs
    logic        exp_cfg, exp_idle, exp_inv;
    logic [15:0] exp_reg;
    int          exp_cnt;

    // Ordered-set tracking: have we seen a comma, are we inside a /C/ payload
    bit          seen_comma;
    bit          in_config;
    logic [7:0]  payload[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_cfg = 0; exp_idle = 0; exp_inv = 0;
        exp_reg = 16'h0000; exp_cnt = 0;
        seen_comma = 0; in_config = 0; payload.delete();
    endtask

    task automatic forget_set();
        seen_comma = 0; in_config = 0; payload.delete();
    endtask

    // One clock's worth of the ordered-set rules, on the inputs being presented
    task automatic model_step(input bit sync, input bit cke, input logic [7:0] cg,
                              input bit ctrl, input bit err, input bit clr);
        exp_cfg = 0; exp_idle = 0; exp_inv = 0;
        if (!sync) begin
            forget_set();
        end else if (cke) begin
            if (err) begin
                exp_inv = 1;
                forget_set();
            end else if (in_config) begin
                if (ctrl) begin
                    exp_inv = 1;
                    forget_set();
                    seen_comma = (cg == 8'hBC);
                end else begin
                    payload.push_back(cg);
                    if (payload.size() == 2) begin
                        exp_reg = {payload[1], payload[0]};
                        exp_cfg = 1;
                        forget_set();
                    end
                end
            end else if (seen_comma) begin
                if (ctrl && cg == 8'hBC) begin
                    seen_comma = 1;
                end else if (!ctrl && (cg == 8'hB5 || cg == 8'h42)) begin
                    seen_comma = 0; in_config = 1; payload.delete();
                end else if (!ctrl && (cg == 8'hC5 || cg == 8'h50)) begin
                    seen_comma = 0; exp_idle = 1;
                end else begin
                    seen_comma = 0; exp_inv = 1;
                end
            end else if (ctrl) begin
                if (cg == 8'hBC) seen_comma = 1;
                else exp_inv = 1;
            end
        end
        if (clr) exp_cnt = 0;
        else if (exp_inv && exp_cnt < 255) exp_cnt++;
    endtask

    task automatic compare_all();
        chk("config", 32'(bus_if.o_RUDIConfig), 32'(exp_cfg));
        chk("idle", 32'(bus_if.o_RUDIIdle), 32'(exp_idle));
        chk("invalid", 32'(bus_if.o_RUDIInvalid), 32'(exp_inv));
        chk("cfg_reg", 32'(bus_if.o16_RxConfigReg), 32'(exp_reg));
        chk("inv_cnt", 32'(bus_if.o8_InvalidCnt), 32'(exp_cnt));
        chk("onehot", 32'(($countones({bus_if.o_RUDIConfig, bus_if.o_RUDIIdle,
                                        bus_if.o_RUDIInvalid}) <= 1)), 32'd1);
    endtask

    // Present one code group for one clock, then check outputs after the edge
    task automatic cycle(input bit cke, input logic [7:0] cg, input bit ctrl,
                         input bit err, input bit clr);
        @(negedge i_Clk);
        bus_if.i_Cke          = cke;
        bus_if.i8_RxCodeGroup = cg;
        bus_if.i_RxCtrl       = ctrl;
        bus_if.i_RxCodeErr    = err;
        bus_if.i_ClrCnt       = clr;
        model_step(bus_if.i_SyncStatus, cke, cg, ctrl, err, clr);
        @(posedge i_Clk);
        #1;
        compare_all();
    endtask

    task automatic kc(input logic [7:0] cg);
        cycle(1, cg, 1, 0, 0);
    endtask

    task automatic dc(input logic [7:0] cg);
        cycle(1, cg, 0, 0, 0);
    endtask

    logic [7:0] rnd_cg;
    bit         rnd_ctrl;

    task automatic pick_symbol();
        int r;
        r = $urandom_range(0, 9);
        case (r)
            0, 1, 2: begin rnd_cg = 8'hBC; rnd_ctrl = 1; end
            3:       begin rnd_cg = ($urandom_range(0, 1) == 0) ? 8'hFC : 8'hF7; rnd_ctrl = 1; end
            4:       begin rnd_cg = 8'hB5; rnd_ctrl = 0; end
            5:       begin rnd_cg = 8'h42; rnd_ctrl = 0; end
            6:       begin rnd_cg = 8'hC5; rnd_ctrl = 0; end
            7:       begin rnd_cg = 8'h50; rnd_ctrl = 0; end
            default: begin rnd_cg = 8'($urandom); rnd_ctrl = 0; end
        endcase
    endtask

    initial begin
        i_ARst_L              = 1'b0;
        bus_if.i_Cke          = 1'b0;
        bus_if.i_SyncStatus   = 1'b1;
        bus_if.i8_RxCodeGroup = 8'h00;
        bus_if.i_RxCtrl       = 1'b0;
        bus_if.i_RxCodeErr    = 1'b0;
        bus_if.i_ClrCnt       = 1'b0;
        model_reset();
        #1;
        compare_all();
        repeat (2) @(posedge i_Clk);
        @(negedge i_Clk);
        i_ARst_L = 1'b1;
        cycle(0, 8'h00, 0, 0, 0);

        // Basic /C/ set
        kc(8'hBC); dc(8'hB5); dc(8'h01); dc(8'hA0);
        chk("c_pulse", 32'(bus_if.o_RUDIConfig), 32'd1);
        chk("c_word", 32'(bus_if.o16_RxConfigReg), 32'hA001);
        dc(8'h00);
        chk("c_single", 32'(bus_if.o_RUDIConfig), 32'd0);

        // Two /I/ sets
        kc(8'hBC); dc(8'hC5);
        chk("i1_pulse", 32'(bus_if.o_RUDIIdle), 32'd1);
        kc(8'hBC); dc(8'h50);
        chk("i2_pulse", 32'(bus_if.o_RUDIIdle), 32'd1);
        chk("i_word_kept", 32'(bus_if.o16_RxConfigReg), 32'hA001);

        // K28.7 inside config payload
        kc(8'hBC); dc(8'h42); dc(8'h20); kc(8'hFC);
        chk("k_in_cfg_inv", 32'(bus_if.o_RUDIInvalid), 32'd1);
        chk("k_in_cfg_cnt", 32'(bus_if.o8_InvalidCnt), 32'd1);
        dc(8'hB5); dc(8'h11);

        // Same config set with strobe toggling, identical decode, one-cycle pulses
        foreach (payload[i]) ;
        begin
            logic [7:0] seq[4];
            bit         sk[4];
            seq = '{8'hBC, 8'hB5, 8'h01, 8'hA0};
            sk  = '{1, 0, 0, 0};
            for (int i = 0; i < 4; i++) begin
                cycle(1, seq[i], sk[i], 0, 0);
                cycle(0, 8'($urandom), 1'($urandom), 1'($urandom), 0);
            end
            chk("cke_word", 32'(bus_if.o16_RxConfigReg), 32'hA001);
        end

        // Code error on high byte, then saturation and clear
        kc(8'hBC); dc(8'hB5); dc(8'h77); cycle(1, 8'h66, 0, 1, 0);
        chk("err_hi_inv", 32'(bus_if.o_RUDIInvalid), 32'd1);
        chk("err_hi_word", 32'(bus_if.o16_RxConfigReg), 32'hA001);
        for (int i = 0; i < 300; i++) cycle(1, 8'($urandom), 1'($urandom), 1, 0);
        chk("cnt_sat", 32'(bus_if.o8_InvalidCnt), 32'hFF);
        cycle(1, 8'hFC, 1, 0, 1);
        chk("cnt_clr", 32'(bus_if.o8_InvalidCnt), 32'h00);

        // Sync loss mid-set
        kc(8'hBC); dc(8'hB5);
        bus_if.i_SyncStatus = 1'b0;
        for (int i = 0; i < 4; i++) cycle(1, 8'($urandom), 1'($urandom), 1'($urandom), 0);
        bus_if.i_SyncStatus = 1'b1;
        kc(8'hBC); dc(8'h42); dc(8'h34); dc(8'h12);
        chk("sync_word", 32'(bus_if.o16_RxConfigReg), 32'h1234);

        // Reset in the middle of an ordered set
        kc(8'hBC); dc(8'hB5); dc(8'h55);
        @(negedge i_Clk);
        i_ARst_L = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(negedge i_Clk);
        i_ARst_L = 1'b1;
        dc(8'hAA); dc(8'h00);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            pick_symbol();
            bus_if.i_SyncStatus = ($urandom_range(0, 29) != 0);
            cycle(($urandom_range(0, 3) != 0), rnd_cg, rnd_ctrl,
                  ($urandom_range(0, 39) == 0), ($urandom_range(0, 59) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
